// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out loader: FSM encoding and
// the counter-width helper used by the serializer and its bit counter.
package serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to hold an index 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Mod-N up-counter with synchronous clear, increment enable and a
// terminal-count flag that is high while the count sits at N-1.
module mod_counter
  import serializer_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] TC_VAL = W'(N - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out loader: takes a WIDTH-bit word over valid/ready and
// streams it one bit per clock, back-to-back words with no idle bubble.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I_DATA,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic             O,
  output logic             O_VALID,
  output logic             O_LAST,
  output logic             DBG_STATE
);

  // Handshake: a word transfers on a rising edge where I_VALID and I_READY are
  // both 1; I_DATA must be held stable by the source until that edge, and
  // I_READY never depends on I_VALID.

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    count;
  logic             tc;
  logic             xfer;
  logic             shifting;
  logic             last_q;

  assign shifting = (state == ST_SHIFT);
  assign I_READY  = !RESET && (state == ST_IDLE || (shifting && tc));
  assign xfer     = I_VALID && I_READY;

  // Vacated positions fill with zero, so the register drains to all-zero by
  // the time the last bit leaves; O is then 0 for free while idle.
  assign shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg[WIDTH-1:1]};

  mod_counter #(
    .N (WIDTH),
    .W (CW)
  ) u_count (
    .clk   (CLK),
    .rst   (RESET),
    .clr   (xfer),
    .inc   (shifting),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      last_q <= 1'b0;
    end else if (xfer) begin
      state  <= ST_SHIFT;
      shreg  <= I_DATA;
      last_q <= 1'b0;
    end else if (shifting) begin
      shreg  <= shifted;
      last_q <= (count == PRE_LAST);
      if (tc) state <= ST_IDLE;
    end
  end

  assign O         = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign O_VALID   = shifting;
  assign O_LAST    = last_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB-first and MSB-first instances share one
// stimulus stream; a bit-queue model predicts every output each cycle.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_data;
  logic       i_valid;

  logic l_ready, l_o, l_valid, l_last, l_dbg;
  logic m_ready, m_o, m_valid, m_last, m_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model: pending output bits, front is what O shows now; entry = {last, bit}
  logic [1:0] exp_l_q[$];
  logic [1:0] exp_m_q[$];

  // Downstream 4-stage serial register fed by the MSB-first output
  logic [3:0] siso_act = '0;
  logic [3:0] siso_exp = '0;

  logic [15:0] col_lo, col_mo, col_v, col_l, col_r, col_s;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .CLK(clk), .RESET(rst), .I_DATA(i_data), .I_VALID(i_valid),
    .I_READY(l_ready), .O(l_o), .O_VALID(l_valid), .O_LAST(l_last),
    .DBG_STATE(l_dbg)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
    .CLK(clk), .RESET(rst), .I_DATA(i_data), .I_VALID(i_valid),
    .I_READY(m_ready), .O(m_o), .O_VALID(m_valid), .O_LAST(m_last),
    .DBG_STATE(m_dbg)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic q_front(input logic [1:0] q[$], input int field);
    if (q.size() == 0) return 1'b0;
    return q[0][field];
  endfunction

  // Model update at each active edge
  always @(posedge clk) begin
    logic ready;
    siso_act <= {siso_act[2:0], m_o};
    siso_exp <= {siso_exp[2:0], q_front(exp_m_q, 0)};
    if (rst) begin
      exp_l_q.delete();
      exp_m_q.delete();
    end else begin
      ready = (exp_l_q.size() == 0) || exp_l_q[0][1];
      if (exp_l_q.size() > 0) void'(exp_l_q.pop_front());
      if (exp_m_q.size() > 0) void'(exp_m_q.pop_front());
      if (i_valid && ready) begin
        for (int i = 0; i < 4; i++) begin
          exp_l_q.push_back({i == 3, i_data[i]});
          exp_m_q.push_back({i == 3, i_data[3-i]});
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic ev, er;
      ev = (exp_l_q.size() > 0);
      er = !rst && ((exp_l_q.size() == 0) || exp_l_q[0][1]);
      check("lsb_o",     l_o,     q_front(exp_l_q, 0));
      check("lsb_valid", l_valid, ev);
      check("lsb_last",  l_last,  q_front(exp_l_q, 1));
      check("lsb_ready", l_ready, er);
      check("lsb_state", l_dbg,   ev);
      check("msb_o",     m_o,     q_front(exp_m_q, 0));
      check("msb_valid", m_valid, exp_m_q.size() > 0);
      check("msb_last",  m_last,  q_front(exp_m_q, 1));
      check("msb_ready", m_ready, er);
      check("siso_o",    siso_act[3], siso_exp[3]);
    end
  end

  // ---------------- driver tasks (all start and end at edge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] w);
    logic took;
    took = 1'b0;
    i_data  = w;
    i_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      took = l_ready;
      @(posedge clk);
      #1;
      if (took) break;
    end
    check("send_handshake", took, 1'b1);
    i_valid = 1'b0;
    i_data  = 4'($urandom_range(0, 15));
  endtask

  task automatic collect(input int n);
    col_lo = '0; col_mo = '0; col_v = '0; col_l = '0; col_r = '0; col_s = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      col_lo[i] = l_o;
      col_mo[i] = m_o;
      col_v[i]  = l_valid;
      col_l[i]  = l_last;
      col_r[i]  = l_ready;
      col_s[i]  = siso_act[3];
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst     = 1'b1;
    i_valid = 1'b1;
    i_data  = 4'hF;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset held with I_VALID=1: everything quiet
    collect(3);
    check("rst_valid", col_v[2:0], 3'b000);
    check("rst_ready", col_r[2:0], 3'b000);
    check("rst_o",     {col_lo[2:0], col_mo[2:0]}, 6'b0);
    rst     = 1'b0;
    i_valid = 1'b0;
    collect(1);
    check("ready_after_rst", col_r[0], 1'b1);

    // Single word, LSB first 1,1,0,1
    send(4'b1011);
    collect(5);
    check("single_lsb_seq", col_lo[4:0], 5'b01011);
    check("single_msb_seq", col_mo[4:0], 5'b01101);
    check("single_valid",   col_v[4:0],  5'b01111);
    check("single_last",    col_l[4:0],  5'b01000);
    idle(2);

    // Back-to-back A then 5: eight consecutive bits
    send(4'hA);
    fork
      send(4'h5);
      collect(9);
    join
    check("b2b_lsb_seq", col_lo[8:0], 9'b001011010);
    check("b2b_msb_seq", col_mo[8:0], 9'b010100101);
    check("b2b_valid",   col_v[8:0],  9'b011111111);
    check("b2b_last",    col_l[8:0],  9'b010001000);
    check("b2b_ready",   col_r[8:0],  9'b110001000);
    idle(5);

    // MSB first 1000, and the downstream register shows it 4 cycles later
    send(4'b1000);
    collect(5);
    check("msb_seq",   col_mo[4:0], 5'b00001);
    check("lsb_seq_8", col_lo[4:0], 5'b01000);
    check("siso_seq",  col_s[4:0],  5'b10000);
    idle(2);

    // Backpressure: next word offered during the second bit of the first
    send(4'h6);
    fork
      begin
        @(posedge clk);
        #1;
        send(4'h9);
      end
      collect(9);
    join
    check("bp_lsb_seq", col_lo[8:0], 9'b010010110);
    check("bp_valid",   col_v[8:0],  9'b011111111);
    check("bp_last",    col_l[8:0],  9'b010001000);
    check("bp_ready",   col_r[8:0],  9'b110001000);
    idle(2);

    // Reset after two bits of F: word dropped, no last marker
    send(4'hF);
    fork
      collect(6);
      begin
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
      end
    join
    check("rstmid_valid", col_v[5:0], 6'b000111);
    check("rstmid_last",  col_l[5:0], 6'b000000);
    check("rstmid_ready", col_r[5:0], 6'b110000);
    send(4'h1);
    collect(5);
    check("post_rst_seq",  col_lo[4:0], 5'b00001);
    check("post_rst_last", col_l[4:0],  5'b01000);
    idle(3);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
